// File: rtl/uart_tx.sv
// uart_tx: 16x-oversampled UART transmitter, 8N1 by default with optional even/odd parity.
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] d_in,
  output logic       tx,
  output logic       tx_done,
  output logic       tx_done_tick
);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  localparam logic [4:0] S_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST = 3'(DBIT - 1);
  state_t     state_q, state_d;
  logic [4:0] s_q, s_d;
  logic [2:0] n_q, n_d;
  logic [7:0] b_q, b_d, data;
  logic       par_q, par_d, tx_q, tx_d, done_q, done_d, tick_q, tick_d, last;
  assign data = DBIT == 7 ? {1'b0, d_in[6:0]} : d_in;
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    par_d   = par_q;
    tick_d  = 1'b0;
    last    = s_q == 5'd15;
    unique case (state_q)
      IDLE: if (tx_start) begin
        b_d     = data;
        par_d   = ^data ^ (PARITY == 2);
        s_d     = '0;
        state_d = START;
      end
      START: if (s_tick) begin
        s_d = last ? 5'd0 : s_q + 5'd1;
        if (last) begin
          n_d     = '0;
          state_d = DATA;
        end
      end
      DATA: if (s_tick) begin
        s_d = last ? 5'd0 : s_q + 5'd1;
        if (last) begin
          b_d = b_q >> 1;
          n_d = n_q + 3'd1;
          if (n_q == N_LAST) state_d = PARITY != 0 ? PAR : STOP;
        end
      end
      PAR: if (s_tick) begin
        s_d = last ? 5'd0 : s_q + 5'd1;
        if (last) state_d = STOP;
      end
      STOP: if (s_tick) begin
        s_d = s_q == S_LAST ? 5'd0 : s_q + 5'd1;
        if (s_q == S_LAST) begin
          state_d = IDLE;
          tick_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // outputs follow the next state so they are registered yet aligned with it
    tx_d   = state_d == START ? 1'b0 : state_d == DATA ? b_d[0] : state_d == PAR ? par_d : 1'b1;
    done_d = state_d == IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      tick_q  <= tick_d;
    end
  end
  assign tx           = tx_q;
  assign tx_done      = done_q;
  assign tx_done_tick = tick_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three transmitters (no/even/odd parity) checked against a tick-position frame model.
module tb_uart_tx;
  logic       clk = 1'b0, reset = 1'b1, s_tick = 1'b0, tx_start = 1'b0, tick_en = 1'b1;
  logic [7:0] d_in = '0;
  logic [2:0] tx, done, dtick;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  uart_tx #(.PARITY(0)) u0 (.clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .d_in(d_in),
                            .tx(tx[0]), .tx_done(done[0]), .tx_done_tick(dtick[0]));
  uart_tx #(.PARITY(1)) u1 (.clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .d_in(d_in),
                            .tx(tx[1]), .tx_done(done[1]), .tx_done_tick(dtick[1]));
  uart_tx #(.PARITY(2)) u2 (.clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .d_in(d_in),
                            .tx(tx[2]), .tx_done(done[2]), .tx_done_tick(dtick[2]));
  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask
  // Model: a frame is a sequence of 16-tick bit slots; t counts ticks since acceptance.
  bit         busy[3], armed = 1'b0;
  int         t[3], tick_cnt[3], pulse_cnt[3];
  logic [7:0] mdata[3];
  logic       etx[3], edone[3], etick[3];
  function automatic int flen(input int k);
    return k == 0 ? 160 : 176;
  endfunction
  function automatic logic bit_at(input int k, input int tt, input logic [7:0] dd);
    int i = tt / 16;
    if (i == 0) return 1'b0;
    if (i <= 8) return dd[i-1];
    if (i == 9 && k != 0) return (^dd) ^ (k == 2);
    return 1'b1;
  endfunction
  always @(posedge clk) begin
    if (reset) armed = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (!reset && s_tick && !done[k]) tick_cnt[k]++;
      if (reset) begin
        busy[k] = 1'b0; etx[k] = 1'b1; edone[k] = 1'b1; etick[k] = 1'b0;
      end else begin
        etick[k] = 1'b0;
        if (!busy[k]) begin
          if (tx_start) begin
            busy[k] = 1'b1; t[k] = 0; mdata[k] = d_in; etx[k] = 1'b0; edone[k] = 1'b0;
          end
        end else if (s_tick) begin
          t[k]++;
          if (t[k] == flen(k)) begin
            busy[k] = 1'b0; etx[k] = 1'b1; edone[k] = 1'b1; etick[k] = 1'b1;
          end else etx[k] = bit_at(k, t[k], mdata[k]);
        end
      end
    end
  end
  always @(negedge clk) begin
    if (armed) for (int k = 0; k < 3; k++) begin
      chk($sformatf("tx%0d", k), tx[k], etx[k]);
      chk($sformatf("done%0d", k), done[k], edone[k]);
      chk($sformatf("tick%0d", k), dtick[k], etick[k]);
      if (dtick[k] === 1'b1) pulse_cnt[k]++;
    end
  end
  initial begin
    int ph = 0;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 4;
      s_tick = tick_en && ph == 0;
    end
  end
  task automatic start_pulse(input logic [7:0] v);
    d_in = v;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask
  task automatic wait_idle(input int maxc);
    int c = 0;
    while (done !== 3'b111 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chki("idle_timeout", int'(done === 3'b111), 1);
    repeat (2) @(negedge clk);
  endtask
  initial begin
    int tb[3], pb[3], el, c;
    logic [9:0] seq41 = 10'b1010000010;
    logic hold;
    repeat (3) @(negedge clk);
    chki("rst_tx", int'(tx), 7);
    chki("rst_done", int'(done), 7);
    chki("rst_tick", int'(dtick), 0);
    reset = 1'b0;
    repeat (500) @(negedge clk);
    chki("idle_tx", int'(tx), 7);
    chki("idle_pulses", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2], 0);
    // single 0x41 frame: hand-computed line levels at each bit centre
    tb = tick_cnt; pb = pulse_cnt;
    start_pulse(8'h41);
    el = 0;
    for (int i = 0; i < 10; i++) begin
      repeat (64 * i + 32 - el) @(negedge clk);
      el = 64 * i + 32;
      chk($sformatf("bit41_%0d", i), tx[0], seq41[i]);
    end
    chk("par_even_41", tx[1], 1'b0);
    chk("par_odd_41", tx[2], 1'b1);
    wait_idle(400);
    chki("len0", tick_cnt[0] - tb[0], 160);
    chki("len1", tick_cnt[1] - tb[1], 176);
    chki("len2", tick_cnt[2] - tb[2], 176);
    for (int k = 0; k < 3; k++) chki($sformatf("pulse41_%0d", k), pulse_cnt[k] - pb[k], 1);
    // 0x07: three ones
    start_pulse(8'h07);
    repeat (608) @(negedge clk);
    chk("par_even_07", tx[1], 1'b1);
    chk("par_odd_07", tx[2], 1'b0);
    chk("stop_07", tx[0], 1'b1);
    wait_idle(400);
    // request while busy is dropped
    pb = pulse_cnt;
    start_pulse(8'h41);
    repeat (200) @(negedge clk);
    start_pulse(8'hFF);
    wait_idle(800);
    repeat (100) @(negedge clk);
    for (int k = 0; k < 3; k++) chki($sformatf("busy_pulse%0d", k), pulse_cnt[k] - pb[k], 1);
    chki("busy_done", int'(done), 7);
    // back-to-back with tx_start held, data changed mid-frame
    pb = pulse_cnt;
    d_in = 8'h55;
    tx_start = 1'b1;
    repeat (300) @(negedge clk);
    d_in = 8'hAA;
    c = 0;
    while (dtick[0] !== 1'b1 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    chki("b2b_tick_seen", int'(dtick[0] === 1'b1), 1);
    chk("b2b_idle_tx", tx[0], 1'b1);
    @(negedge clk);
    chk("b2b_gap_tx", tx[0], 1'b0);
    chk("b2b_gap_done", done[0], 1'b0);
    repeat (100) @(negedge clk);
    tx_start = 1'b0;
    wait_idle(1500);
    for (int k = 0; k < 3; k++) chki($sformatf("b2b_pulse%0d", k), pulse_cnt[k] - pb[k], 2);
    // reset mid-frame during data bit 4, with tx_start also high
    pb = pulse_cnt;
    start_pulse(8'h41);
    repeat (288) @(negedge clk);
    reset = 1'b1;
    tx_start = 1'b1;
    d_in = 8'hFF;
    @(negedge clk);
    chki("mid_rst_tx", int'(tx), 7);
    chki("mid_rst_done", int'(done), 7);
    reset = 1'b0;
    tx_start = 1'b0;
    repeat (3) @(negedge clk);
    chki("rst_wins_done", int'(done), 7);
    for (int k = 0; k < 3; k++) chki($sformatf("rst_nopulse%0d", k), pulse_cnt[k] - pb[k], 0);
    // clean frame afterwards, with a pause in s_tick
    start_pulse(8'h33);
    repeat (150) @(negedge clk);
    tick_en = 1'b0;
    @(negedge clk);
    hold = tx[0];
    repeat (100) @(negedge clk);
    chk("no_tick_hold", tx[0], hold);
    chk("no_tick_busy", done[0], 1'b0);
    tick_en = 1'b1;
    wait_idle(800);
    for (int k = 0; k < 3; k++) chki($sformatf("post_rst_pulse%0d", k), pulse_cnt[k] - pb[k], 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
